// File: rtl/dark_pkg.sv
// Shared types for the dark-mode output stage.
// Mode override encoding and the default pixel type.
package dark_pkg;

  localparam int BPC_DEF = 8;

  typedef logic [3*BPC_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    FORCE_AUTO,
    FORCE_OFF,
    FORCE_ON,
    FORCE_AUTO2
  } force_t;

  function automatic logic resolve_mode(
    input force_t f,
    input logic   auto_m
  );
    logic m;
    m = auto_m;
    unique case (f)
      FORCE_OFF: m = 1'b0;
      FORCE_ON:  m = 1'b1;
      default:   m = auto_m;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dark_mux_line_debounce.sv
// Line-end detect, verdict debounce and force resolution.
// Debouncer enabled by DARK_MUX_DEBOUNCE_EN, else mode follows each line verdict.
module line_debounce
  import dark_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       de_i,
  input  logic       rx_i,
  input  logic [1:0] force_i,
  output logic       mode_o
);

  logic de_r_q, de_r_d;
  logic mode_a_q, mode_a_d;
  logic mode_q, mode_d;
  logic line_end;

  assign line_end = ~de_i & de_r_q;
  assign de_r_d   = de_i;

`ifdef DARK_MUX_DEBOUNCE_EN
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mode_a_d = mode_a_q;
    cnt_d    = cnt_q;
    if (line_end) begin
      if (rx_i == mode_a_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        mode_a_d = rx_i;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  always_comb begin
    mode_a_d = mode_a_q;
    if (line_end && HOLD != 0) mode_a_d = rx_i;
  end
`endif

  // Force uses this cycle's verdict so the new line sees it at once.
  always_comb begin
    mode_d = mode_q;
    if (line_end) mode_d = resolve_mode(force_t'(force_i), mode_a_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      de_r_q   <= 1'b0;
      mode_a_q <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      de_r_q   <= de_r_d;
      mode_a_q <= mode_a_d;
      mode_q   <= mode_d;
    end
  end

  assign mode_o = mode_q;

endmodule

// File: rtl/dark_mux.sv
// Two-stage video pipeline inverting RGB when dark mode is applied.
// DARK_MUX_DEBOUNCE_EN selects the HOLD-line debounced mode switch.
module dark_mux
  import dark_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int BPC  = BPC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic [1:0]       force_i,
  input  logic             vs_i,
  input  logic             hs_i,
  input  logic             de_i,
  input  logic [3*BPC-1:0] data_i,
  output logic             vs_o,
  output logic             hs_o,
  output logic             de_o,
  output logic [3*BPC-1:0] data_o,
  output logic             mode_o
);

  logic             mode;
  logic             vs1_q, vs1_d, hs1_q, hs1_d;
  logic             de1_q, de1_d, md1_q, md1_d;
  logic [3*BPC-1:0] px1_q, px1_d;
  logic             vs2_q, vs2_d, hs2_q, hs2_d;
  logic             de2_q, de2_d;
  logic [3*BPC-1:0] px2_q, px2_d;

  line_debounce #(
    .HOLD(HOLD)
  ) u_deb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .de_i   (de_i),
    .rx_i   (rx_i),
    .force_i(force_i),
    .mode_o (mode)
  );

  // Full-word complement equals max-minus-c on every component.
  always_comb begin
    vs1_d = vs_i;
    hs1_d = hs_i;
    de1_d = de_i;
    px1_d = data_i;
    md1_d = mode;
    vs2_d = vs1_q;
    hs2_d = hs1_q;
    de2_d = de1_q;
    px2_d = '0;
    if (de1_q) px2_d = md1_q ? ~px1_q : px1_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vs1_q <= 1'b0;
      hs1_q <= 1'b0;
      de1_q <= 1'b0;
      md1_q <= 1'b0;
      px1_q <= '0;
      vs2_q <= 1'b0;
      hs2_q <= 1'b0;
      de2_q <= 1'b0;
      px2_q <= '0;
    end else begin
      vs1_q <= vs1_d;
      hs1_q <= hs1_d;
      de1_q <= de1_d;
      md1_q <= md1_d;
      px1_q <= px1_d;
      vs2_q <= vs2_d;
      hs2_q <= hs2_d;
      de2_q <= de2_d;
      px2_q <= px2_d;
    end
  end

  assign vs_o   = vs2_q;
  assign hs_o   = hs2_q;
  assign de_o   = de2_q;
  assign data_o = px2_q;
  assign mode_o = mode;

endmodule

// File: doc/dark_mux.md
# dark_mux

Per-pixel output stage directly downstream of `lin_buffer`. Consumes the per-line dark/light verdict `rx_o` and the raw video stream, latches a display mode at line boundaries, and inverts RGB components when dark mode is active. All video and sync signals pass through a fixed two-cycle pipeline, so alignment is preserved to the transmitter.

## Interface
Parameters:
- `HOLD`, default 4: consecutive disagreeing line verdicts required before the mode flips (debounce build only); legal range 1..255.
- `BPC`, default 8: bits per colour component.

Ports:
- `clk_i`  in  1  pixel clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `rx_i`  in  1  line verdict from `lin_buffer` (1 = bright content, invert).
- `force_i`  in  2  mode override: 00 auto, 01 force off, 10 force on, 11 auto.
- `vs_i`  in  1  vertical sync.
- `hs_i`  in  1  horizontal sync.
- `de_i`  in  1  data enable.
- `data_i`  in  3*BPC  pixel, {R,G,B}.
- `vs_o`  out  1  delayed vs.
- `hs_o`  out  1  delayed hs.
- `de_o`  out  1  delayed de.
- `data_o`  out  3*BPC  processed pixel.
- `mode_o`  out  1  current applied mode (1 = inverting).

## Operation
- Internal `de_r` is `de_i` delayed one cycle. Line end: `~de_i && de_r`.
- At every line end, sample `rx_i` into the debouncer. At any other cycle `rx_i` is ignored.
- Auto mode register `mode_a` changes only at line end, never during active video.
- Debouncer state: `mode_a` plus counter `cnt` (width `$clog2(HOLD+1)`).
  - Line end, `rx_i == mode_a`: `cnt` ← 0.
  - Line end, `rx_i != mode_a`, `cnt == HOLD-1`: `mode_a` ← `rx_i`, `cnt` ← 0.
  - Line end, `rx_i != mode_a`, otherwise: `cnt` ← `cnt+1`.
  - `cnt` never exceeds HOLD-1.
- Effective mode: `force_i`=01 → 0; 10 → 1; 00/11 → `mode_a`. `force_i` is sampled only at line end, into a registered `mode_o`, so the applied mode is constant across a line.
- Stage 1: register `vs`, `hs`, `de`, `data`, and the mode.
- Stage 2: if `mode` and `de` are both set, each component becomes `(2^BPC-1) - c`; otherwise it passes unchanged. `data_o` is forced to 0 when stage-2 `de` is 0.
- Arithmetic: the bitwise complement per component is exact; no carry or saturation.

## Timing
- Latency: `vs_o`/`hs_o`/`de_o`/`data_o` equal the inputs from 2 cycles earlier, with `data` processed.
- `mode_o` updates on the cycle after a line end. It first affects the pixel output on the next line's first `de_o` cycle.
- Reset (`rst_ni`=0 at a clock edge): all outputs 0, `mode_a`=0, `cnt`=0, `de_r`=0, pipeline cleared. Reset mid-line drops the remainder of that line; the first line end after release is still a valid sample.
- Line end coinciding with `force_i` change: the new `force_i` value is used.
- `rx_i` toggling mid-line: no effect.

## Configuration
- `DARK_MUX_DEBOUNCE_EN` defined: debouncer as above, `HOLD` honoured.
- Not defined: `cnt` is absent and `mode_a` ← `rx_i` at every line end (equivalent to HOLD=1). The `HOLD` parameter is accepted and ignored. Latency is unchanged.

## Structure
- Shared package `dark_pkg`:
  - `BPC_DEF` = 8.
  - `typedef logic [3*BPC_DEF-1:0] pixel_t`.
  - `typedef enum logic [1:0] {FORCE_AUTO, FORCE_OFF, FORCE_ON, FORCE_AUTO2} force_t`.
- One sub-module, `line_debounce`: line-end detect, `cnt`, `mode_a`, force resolution; outputs the registered mode. The pixel pipeline stays in `dark_mux`.

## Test plan
- Reset: hold `rst_ni`=0 for 3 cycles with `de_i`=1 and `data_i`=0x123456 → all outputs 0, `mode_o`=0; after release, `data_o`=0x123456 two cycles after input.
- Debounce, HOLD=4, macro on: `rx_i`=1 at line ends 1–3 → `mode_o`=0; line end 4 → `mode_o`=1; line 5 pixel 0x102030 → `data_o`=0xEFDFCF.
- Counter clear: `rx_i` pattern 1,1,1,0,1,1,1 at line ends → `mode_o` stays 0 throughout.
- Force: `force_i`=10, `rx_i`=0 → after the next line end, `mode_o`=1 and pixel 0x000000 → 0xFFFFFF. `force_i`=01 → pass-through.
- Mid-line stability: toggle `rx_i` and `force_i` during `de_i`=1 → `data_o` mode constant within the line; blanking `data_o`=0; syncs delayed exactly 2 cycles.
- Macro off: `rx_i`=1 at a single line end → `mode_o`=1 on the next cycle.
